// File: rtl/apb_nslv_master_pkg.sv
// Shared types and constants for the N-slave APB master and its address decoder.
package apb_nslv_master_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS
  } apb_state_e;

  localparam apb_state_e RST_STATE = IDLE;

  // Slave-index width; a single slave still needs one select bit.
  function automatic int unsigned sel_width(input int unsigned num_slv);
    return (num_slv < 2) ? 1 : $clog2(num_slv);
  endfunction

endpackage

// File: rtl/apb_nslv_master_addr_decoder.sv
// Combinational address decoder: top SEL_W address bits pick the slave; indices >= NUM_SLV are unmapped.
module apb_addr_decoder
  import apb_nslv_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = sel_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               unmapped_o
);

  logic unused_addr_lo;

  assign idx_o          = addr_i[ADDR_W-1 -: SEL_W];
  assign unused_addr_lo = ^addr_i[ADDR_W-SEL_W-1:0];

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_o == SEL_W'(i)) sel_o[i] = 1'b1;
    end
  end

  assign unmapped_o = ~|sel_o;

endmodule

// File: rtl/apb_nslv_master.sv
// APB master with built-in N-slave decoder: valid/ready request in, one-cycle response pulse out.
// Optional PREADY timeout enabled by defining APB_TIMEOUT_EN.
module apb_nslv_master
  import apb_nslv_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int unsigned SEL_W = sel_width(NUM_SLV);

  if (NUM_SLV < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("apb_nslv_master: NUM_SLV must be >= 2 and TIMEOUT_CYC >= 1");
  end

  apb_state_e           state_q, state_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [NUM_SLV-1:0]   dec_sel;
  logic [SEL_W-1:0]     dec_idx;
  logic                 dec_unmapped;

  logic [DATA_W-1:0]    rd_sel;
  logic                 rdy_sel;
  logic                 err_sel;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  apb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .addr_i     (req_addr),
    .sel_o      (dec_sel),
    .idx_o      (dec_idx),
    .unmapped_o (dec_unmapped)
  );

  // Only the selected slave's PREADY/PSLVERR/PRDATA are observed.
  always_comb begin
    rd_sel  = '0;
    rdy_sel = 1'b0;
    err_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SEL_W'(i)) begin
        rd_sel  = PRDATA[i*DATA_W +: DATA_W];
        rdy_sel = PREADY[i];
        err_sel = PSLVERR[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          if (dec_unmapped) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = SETUP;
            psel_d  = dec_sel;
            idx_d   = dec_idx;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (rdy_sel) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : rd_sel;
          rsp_err_d   = err_sel;
        end
`ifdef APB_TIMEOUT_EN
        // Abort on the edge that would make the wait count reach TIMEOUT_CYC.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= RST_STATE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_nslv_master.sv
// Directed bench for apb_nslv_master: a 4-slave instance for the main flows, a 3-slave one for unmapped decode.
module tb_apb_nslv_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_valid3, req_write;
  logic [8:0]  req_addr;
  logic [7:0]  req_wdata;

  logic        req_ready4, rsp_valid4, rsp_err4, penable4, pwrite4;
  logic [7:0]  rsp_rdata4, pwdata4;
  logic [3:0]  psel4, pready4, pslverr4;
  logic [8:0]  paddr4;
  logic [31:0] prdata4;

  logic        req_ready3, rsp_valid3, rsp_err3, penable3, pwrite3;
  logic [7:0]  rsp_rdata3, pwdata3;
  logic [2:0]  psel3, pready3, pslverr3;
  logic [8:0]  paddr3;
  logic [23:0] prdata3;

  int checks = 0;
  int errors = 0;
  int acc;
  int got;

  apb_nslv_master #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(4), .TIMEOUT_CYC(16)) u_dut4 (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(req_ready4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .PSEL(psel4), .PENABLE(penable4), .PWRITE(pwrite4), .PADDR(paddr4), .PWDATA(pwdata4),
    .PRDATA(prdata4), .PREADY(pready4), .PSLVERR(pslverr4)
  );

  apb_nslv_master #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT_CYC(16)) u_dut3 (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite3), .PADDR(paddr3), .PWDATA(pwdata3),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [8:0] addr, input logic [7:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_psel"},    32'(psel4),      32'h0);
    check({tag, "_penable"}, 32'(penable4),   32'h0);
    check({tag, "_pwrite"},  32'(pwrite4),    32'h0);
    check({tag, "_paddr"},   32'(paddr4),     32'h0);
    check({tag, "_pwdata"},  32'(pwdata4),    32'h0);
    check({tag, "_rvalid"},  32'(rsp_valid4), 32'h0);
    check({tag, "_rdata"},   32'(rsp_rdata4), 32'h0);
    check({tag, "_rerr"},    32'(rsp_err4),   32'h0);
    check({tag, "_ready"},   32'(req_ready4), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0;
    pready4 = 4'hF; pslverr4 = '0; prdata4 = '0;
    pready3 = 3'b111; pslverr3 = '0; prdata3 = 24'h777777;
    #1 rst = 1'b1;
    #1 check_outputs_zero("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T1: zero-wait write to slave 1 (0x0C0 -> index 1)
    check("t1_ready", 32'(req_ready4), 32'h1);
    drive_req(1'b1, 9'h0C0, 8'h5A);
    @(negedge clk); req_valid = 1'b0;
    check("t1_setup_psel",  32'(psel4),      32'h2);
    check("t1_setup_pen",   32'(penable4),   32'h0);
    check("t1_paddr",       32'(paddr4),     32'h0C0);
    check("t1_pwdata",      32'(pwdata4),    32'h5A);
    check("t1_pwrite",      32'(pwrite4),    32'h1);
    check("t1_busy",        32'(req_ready4), 32'h0);
    @(negedge clk);
    check("t1_acc_pen",     32'(penable4),   32'h1);
    check("t1_acc_psel",    32'(psel4),      32'h2);
    check("t1_acc_rvalid",  32'(rsp_valid4), 32'h0);
    @(negedge clk);
    check("t1_rvalid",      32'(rsp_valid4), 32'h1);
    check("t1_rerr",        32'(rsp_err4),   32'h0);
    check("t1_rdata",       32'(rsp_rdata4), 32'h0);
    check("t1_done_psel",   32'(psel4),      32'h0);
    check("t1_done_pen",    32'(penable4),   32'h0);
    @(negedge clk);
    check("t1_pulse_end",   32'(rsp_valid4), 32'h0);
    check("t1_paddr_hold",  32'(paddr4),     32'h0C0);

    // T2: read slave 3 with 3 wait states; other slaves ready with errors and junk data
    pready4 = 4'b0111; pslverr4 = 4'b0111; prdata4 = {8'hA5, 8'h33, 8'h22, 8'h11};
    drive_req(1'b0, 9'h1C0, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    check("t2_psel", 32'(psel4), 32'h8);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      check("t2_acc_pen",    32'(penable4),   32'h1);
      check("t2_acc_rvalid", 32'(rsp_valid4), 32'h0);
      if (w == 3) pready4 = 4'b1111;
    end
    @(negedge clk);
    check("t2_rvalid", 32'(rsp_valid4), 32'h1);
    check("t2_rdata",  32'(rsp_rdata4), 32'hA5);
    check("t2_rerr",   32'(rsp_err4),   32'h0);
    check("t2_psel0",  32'(psel4),      32'h0);
    pslverr4 = '0;

    // T3: 3-slave instance: mapped read of slave 0, then unmapped index 3
    drive_req(1'b0, 9'h040, 8'h00); req_valid = 1'b0; req_valid3 = 1'b1;
    @(negedge clk); req_valid3 = 1'b0;
    check("t3_map_psel", 32'(psel3), 32'h1);
    repeat (2) @(negedge clk);
    check("t3_map_rvalid", 32'(rsp_valid3), 32'h1);
    check("t3_map_rdata",  32'(rsp_rdata3), 32'h77);
    req_addr = 9'h1C0; req_valid3 = 1'b1;
    @(negedge clk); req_valid3 = 1'b0;
    check("t3_rvalid", 32'(rsp_valid3), 32'h1);
    check("t3_rerr",   32'(rsp_err3),   32'h1);
    check("t3_rdata",  32'(rsp_rdata3), 32'h0);
    check("t3_psel",   32'(psel3),      32'h0);
    check("t3_ready",  32'(req_ready3), 32'h1);
    @(negedge clk);
    check("t3_pulse_end", 32'(rsp_valid3), 32'h0);
    check("t3_err_hold",  32'(rsp_err3),   32'h1);

    // T4: slave 1 errors; back-to-back request accepted in the response cycle
    pslverr4 = 4'b0010;
    drive_req(1'b1, 9'h080, 8'hC3);
    @(negedge clk); req_valid = 1'b0;
    check("t4_psel", 32'(psel4), 32'h2);
    @(negedge clk);
    @(negedge clk);
    check("t4_rvalid", 32'(rsp_valid4), 32'h1);
    check("t4_rerr",   32'(rsp_err4),   32'h1);
    check("t4_psel0",  32'(psel4),      32'h0);
    check("t4_ready",  32'(req_ready4), 32'h1);
    pslverr4 = '0; prdata4 = {8'hA5, 8'h33, 8'h22, 8'h3C};
    drive_req(1'b0, 9'h040, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    check("t4b_rvalid0", 32'(rsp_valid4), 32'h0);
    check("t4b_psel",    32'(psel4),      32'h1);
    check("t4b_errhold", 32'(rsp_err4),   32'h1);
    @(negedge clk);
    check("t4b_pen", 32'(penable4), 32'h1);
    @(negedge clk);
    check("t4b_rvalid", 32'(rsp_valid4), 32'h1);
    check("t4b_rdata",  32'(rsp_rdata4), 32'h3C);
    check("t4b_rerr",   32'(rsp_err4),   32'h0);

    // T5: slave never ready
    @(negedge clk);
    pready4 = '0;
    drive_req(1'b0, 9'h1C0, 8'h00);
    @(negedge clk); req_valid = 1'b0;
    acc = 0; got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      @(negedge clk);
      if (rsp_valid4) got = 1;
      else if (penable4) acc++;
    end
`ifdef APB_TIMEOUT_EN
    check("t5_rsp_seen",   32'(got),        32'h1);
    check("t5_acc_cycles", 32'(acc),        32'd16);
    check("t5_rerr",       32'(rsp_err4),   32'h1);
    check("t5_rdata",      32'(rsp_rdata4), 32'h0);
    check("t5_psel0",      32'(psel4),      32'h0);
    check("t5_pen0",       32'(penable4),   32'h0);
`else
    check("t5_no_rsp",    32'(got),      32'h0);
    check("t5_acc_cycles",32'(acc),      32'd40);
    check("t5_still_pen", 32'(penable4), 32'h1);
    check("t5_still_sel", 32'(psel4),    32'h8);
`endif

    // T6: reset pulse during ACCESS
`ifdef APB_TIMEOUT_EN
    @(negedge clk);
    drive_req(1'b1, 9'h1C0, 8'h99);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
`endif
    check("t6_in_access", 32'(penable4), 32'h1);
    #2 rst = 1'b1;
    pready4 = 4'hF;
    #1 check_outputs_zero("t6");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_rsp", 32'(rsp_valid4), 32'h0);
      check("t6_ready",  32'(req_ready4), 32'h1);
      check("t6_psel",   32'(psel4),      32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
